// File: rtl/quantum_arbiter_pkg.sv
// Shared constants for the quantum arbiter: state encodings and the
// constant-width helper used to size the pointer and the quantum timer.
package quantum_arbiter_pkg;

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_GRANT = 1'b1;

  // Ceiling log2 clamped to a minimum of 1 so degenerate values still give a usable vector.
  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned bits;
    bits = 0;
    while ((64'd1 << bits) < 64'(value)) bits++;
    return (bits == 0) ? 1 : bits;
  endfunction

endpackage

// File: rtl/quantum_arbiter_timer.sv
// Quantum timer: loadable down-counter that flags zero when the current tenure
// has used its last cycle. quantum=0 keeps the counter parked at zero.
module quantum_arbiter_timer
  import quantum_arbiter_pkg::*;
#(
  parameter int unsigned quantum = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic i_load,
  input  logic i_enable,
  output logic o_zero
);

  localparam int unsigned TW = clog2_min1(quantum);
  localparam logic [TW-1:0] LOAD_VAL = (quantum == 0) ? '0 : TW'(quantum - 1);

  logic [TW-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (quantum == 0) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - TW'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/quantum_arbiter.sv
// Round-robin arbiter with a per-tenure time quantum and a pulsed expiry output.
// Optional macro QUANTUM_ARBITER_PARK_EN keeps grant parked on the last owner while idle.
module quantum_arbiter
  import quantum_arbiter_pkg::*;
#(
  parameter int unsigned width   = 4,
  parameter int unsigned quantum = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [width-1:0] i_req,
  output logic [width-1:0] o_grant,
  output logic             o_grant_valid,
  output logic             o_expired
);

  localparam int unsigned IW = clog2_min1(width);
  localparam logic [IW-1:0] LAST_IDX = IW'(width - 1);

  typedef enum logic {
    IDLE  = STATE_IDLE,
    GRANT = STATE_GRANT
  } state_e;

  state_e           r_state;
  logic [width-1:0] r_grant;
  logic             r_grant_valid;
  logic             r_expired;
  logic [IW-1:0]    r_ptr;

  state_e           w_state_d;
  logic [width-1:0] w_grant_d;
  logic             w_grant_valid_d;
  logic             w_expired_d;
  logic [IW-1:0]    w_ptr_d;
  logic             w_timer_load;
  logic             w_timer_en;
  logic             w_timer_zero;

  logic [width-1:0] w_cand;
  logic [width-1:0] w_win_onehot;
  logic [width-1:0] w_idle_grant;
  logic [IW-1:0]    w_idx;
  logic [IW-1:0]    w_winner;
  logic [IW-1:0]    w_winner_next;
  logic             w_found;
  logic             w_owner_req;

  quantum_arbiter_timer #(
    .quantum (quantum)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .i_load   (w_timer_load),
    .i_enable (w_timer_en),
    .o_zero   (w_timer_zero)
  );

  // In GRANT the owner is excluded, so a release or expiry always looks elsewhere first.
  assign w_cand      = (r_state == GRANT) ? (i_req & ~r_grant) : i_req;
  assign w_owner_req = |(i_req & r_grant);

`ifdef QUANTUM_ARBITER_PARK_EN
  assign w_idle_grant = r_grant;
`else
  assign w_idle_grant = '0;
`endif

  // Round-robin scan starting at the pointer, wrapping at width-1.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = r_ptr;
    for (int k = 0; k < int'(width); k++) begin
      if (!w_found && w_cand[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
      w_idx = (w_idx == LAST_IDX) ? '0 : w_idx + IW'(1);
    end
  end

  assign w_win_onehot  = {{(width-1){1'b0}}, 1'b1} << w_winner;
  assign w_winner_next = (w_winner == LAST_IDX) ? '0 : w_winner + IW'(1);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_d       = r_state;
    w_grant_d       = r_grant;
    w_grant_valid_d = r_grant_valid;
    w_expired_d     = 1'b0;
    w_ptr_d         = r_ptr;
    w_timer_load    = 1'b0;
    w_timer_en      = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_grant_d       = w_idle_grant;
        w_grant_valid_d = 1'b0;
        if (w_found) begin
          w_state_d       = GRANT;
          w_grant_d       = w_win_onehot;
          w_grant_valid_d = 1'b1;
          w_ptr_d         = w_winner_next;
          w_timer_load    = 1'b1;
        end
      end

      GRANT: begin
        if (!w_owner_req) begin
          // Release takes priority over a coincident expiry.
          if (w_found) begin
            w_grant_d    = w_win_onehot;
            w_ptr_d      = w_winner_next;
            w_timer_load = 1'b1;
          end else begin
            w_state_d       = IDLE;
            w_grant_d       = w_idle_grant;
            w_grant_valid_d = 1'b0;
          end
        end else if ((quantum != 0) && w_timer_zero) begin
          w_expired_d  = 1'b1;
          w_timer_load = 1'b1;
          if (w_found) begin
            w_grant_d = w_win_onehot;
            w_ptr_d   = w_winner_next;
          end
        end else begin
          w_timer_en = 1'b1;
        end
      end

      default: begin
        w_state_d       = IDLE;
        w_grant_d       = '0;
        w_grant_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_expired     <= 1'b0;
      r_ptr         <= '0;
    end else begin
      r_state       <= w_state_d;
      r_grant       <= w_grant_d;
      r_grant_valid <= w_grant_valid_d;
      r_expired     <= w_expired_d;
      r_ptr         <= w_ptr_d;
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_valid = r_grant_valid;
  assign o_expired     = r_expired;

endmodule

// File: tb/tb_quantum_arbiter.sv
// Directed bench for quantum_arbiter with width=4, quantum=4; outputs sampled on the falling edge.
module tb_quantum_arbiter;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic [3:0] grant;
  logic       grant_valid;
  logic       expired;

  int n_checks;
  int n_fail;

  quantum_arbiter #(
    .width   (4),
    .quantum (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .i_req         (req),
    .o_grant       (grant),
    .o_grant_valid (grant_valid),
    .o_expired     (expired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    req   = 4'b0000;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req   = 4'b1111;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    n_checks++;
    if (grant !== 4'b0000) begin
      n_fail++; $display("FAIL reset_grant: got %b, required 0000", grant);
    end
    n_checks++;
    if (grant_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b, required 0", grant_valid);
    end
    n_checks++;
    if (expired !== 1'b0) begin
      n_fail++; $display("FAIL reset_expired: got %b, required 0", expired);
    end
    req   = 4'b0000;
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (grant_valid !== 1'b0 || grant !== 4'b0000) begin
      n_fail++; $display("FAIL idle_after_reset: got grant=%b valid=%b, required 0000/0", grant, grant_valid);
    end
  endtask

  task automatic test_single();
    logic exp_e;
    do_reset();
    req = 4'b0001;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      exp_e = (c == 5) || (c == 9);
      n_checks++;
      if (grant !== 4'b0001 || grant_valid !== 1'b1) begin
        n_fail++; $display("FAIL single_grant c=%0d: got %b/%b, required 0001/1", c, grant, grant_valid);
      end
      n_checks++;
      if (expired !== exp_e) begin
        n_fail++; $display("FAIL single_expired c=%0d: got %b, required %b", c, expired, exp_e);
      end
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g;
    logic       exp_e;
    do_reset();
    req = 4'b1111;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      exp_g = 4'b0001 << (((c - 1) / 4) % 4);
      exp_e = (c > 1) && (((c - 1) % 4) == 0);
      n_checks++;
      if (grant !== exp_g || grant_valid !== 1'b1) begin
        n_fail++; $display("FAIL rotation_grant c=%0d: got %b/%b, required %b/1", c, grant, grant_valid, exp_g);
      end
      n_checks++;
      if (expired !== exp_e) begin
        n_fail++; $display("FAIL rotation_expired c=%0d: got %b, required %b", c, expired, exp_e);
      end
    end
  endtask

  task automatic test_early_release();
    logic [3:0] exp_g;
    logic       exp_e;
    do_reset();
    req = 4'b0011;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      exp_g = (c <= 2) ? 4'b0001 : 4'b0010;
      exp_e = (c == 7);
      n_checks++;
      if (grant !== exp_g || grant_valid !== 1'b1) begin
        n_fail++; $display("FAIL early_release_grant c=%0d: got %b/%b, required %b/1", c, grant, grant_valid, exp_g);
      end
      n_checks++;
      if (expired !== exp_e) begin
        n_fail++; $display("FAIL early_release_expired c=%0d: got %b, required %b", c, expired, exp_e);
      end
      if (c == 2) req = 4'b0010;
    end
  endtask

  task automatic test_release_idle();
    logic [3:0] exp_idle;
`ifdef QUANTUM_ARBITER_PARK_EN
    exp_idle = 4'b0100;
`else
    exp_idle = 4'b0000;
`endif
    do_reset();
    req = 4'b0100;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      n_checks++;
      if (c <= 2) begin
        if (grant !== 4'b0100 || grant_valid !== 1'b1 || expired !== 1'b0) begin
          n_fail++; $display("FAIL release_idle_hold c=%0d: got %b/%b/%b, required 0100/1/0", c, grant, grant_valid, expired);
        end
      end else begin
        if (grant !== exp_idle || grant_valid !== 1'b0 || expired !== 1'b0) begin
          n_fail++; $display("FAIL release_idle_drop c=%0d: got %b/%b/%b, required %b/0/0", c, grant, grant_valid, expired, exp_idle);
        end
      end
      if (c == 2) req = 4'b0000;
    end
  endtask

  task automatic test_coincide();
    do_reset();
    req = 4'b0110;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      n_checks++;
      if (grant !== 4'b0010 || expired !== 1'b0) begin
        n_fail++; $display("FAIL coincide_owner c=%0d: got %b/%b, required 0010/0", c, grant, expired);
      end
    end
    req = 4'b0100;
    @(negedge clock);
    n_checks++;
    if (grant !== 4'b0100 || grant_valid !== 1'b1) begin
      n_fail++; $display("FAIL coincide_next_grant: got %b/%b, required 0100/1", grant, grant_valid);
    end
    n_checks++;
    if (expired !== 1'b0) begin
      n_fail++; $display("FAIL coincide_expired: got %b, required 0", expired);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b1111;
    for (int c = 1; c <= 10; c++) @(negedge clock);
    n_checks++;
    if (grant !== 4'b0100 || grant_valid !== 1'b1) begin
      n_fail++; $display("FAIL async_pre_grant: got %b/%b, required 0100/1", grant, grant_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || expired !== 1'b0) begin
      n_fail++; $display("FAIL async_clear: got %b/%b/%b, required 0000/0/0", grant, grant_valid, expired);
    end
    #1;
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (grant !== 4'b0001 || grant_valid !== 1'b1) begin
      n_fail++; $display("FAIL async_first_grant: got %b/%b, required 0001/1", grant, grant_valid);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    req      = 4'b0000;
    test_reset();
    test_single();
    test_rotation();
    test_early_release();
    test_release_idle();
    test_coincide();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
